// File: rtl/extmem_ws_if.sv
// Bus-side handshake bundle for the external-memory wait-state controller.
// Carries the decode/qualifier inputs and exposes the controller's internal
// acknowledge/error registers and FSM state for observation. The shared,
// tri-stated dtack/berr pins are plain ports on the controller itself.
//
// Handshake: a bus cycle starts when enable rises while the controller is
// idle. enable must stay high until dtack or berr is seen, then fall for at
// least one clock edge before the next cycle. rom and rw are only sampled
// on the accepting edge. ext_ready is sampled only while waiting.
interface extmem_ws_if;
    logic       enable;
    logic       rom;
    logic       rw;
    logic       ext_ready;
    logic       dtack_r;
    logic       berr_r;
    logic [1:0] state;

    modport master (
        output enable,
        output rom,
        output rw,
        output ext_ready,
        input  dtack_r,
        input  berr_r,
        input  state
    );

    modport slave (
        input  enable,
        input  rom,
        input  rw,
        input  ext_ready,
        output dtack_r,
        output berr_r,
        output state
    );
endinterface

// File: rtl/extmem_ws.sv
// Wait-state and bus-error controller for external RAM/ROM.
// Delays dtack by a per-region number of cycles, optionally stretches the
// access until ext_ready, and raises berr on timeout or on a write to a
// write-protected ROM. dtack/berr are only driven while enable selects us.
module extmem_ws #(
    parameter int unsigned RAM_WAIT   = 0,
    parameter int unsigned ROM_WAIT   = 1,
    parameter int unsigned WAIT_WIDTH = 4,
    parameter int unsigned TIMEOUT    = 32,
    parameter int unsigned TO_WIDTH   = 8,
    parameter int unsigned ROM_WP     = 1
) (
    input  logic        clk,
    input  logic        reset,
    extmem_ws_if.slave  bus,
    output logic        dtack,
    output logic        berr
);

    // FSM encoding; IDLE must be zero so the debug state reads 0 after reset.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    // Parameter values resized to the counter widths they are compared with.
    localparam logic [WAIT_WIDTH-1:0] RAM_WC  = RAM_WAIT[WAIT_WIDTH-1:0];
    localparam logic [WAIT_WIDTH-1:0] ROM_WC  = ROM_WAIT[WAIT_WIDTH-1:0];
    localparam logic [WAIT_WIDTH-1:0] WC_ZERO = '0;
    localparam logic [TO_WIDTH-1:0]   TC_MAX  = TIMEOUT[TO_WIDTH-1:0];
    localparam logic [TO_WIDTH-1:0]   TC_ZERO = '0;
    localparam logic [TO_WIDTH-1:0]   TC_ONE  = {{(TO_WIDTH-1){1'b0}}, 1'b1};
    localparam logic                  WP_ON   = (ROM_WP != 0);

    logic [1:0]            state_q, state_d;
    logic [WAIT_WIDTH-1:0] wc_q,    wc_d;
    logic [TO_WIDTH-1:0]   tc_q,    tc_d;
    logic                  dtack_q, dtack_d;
    logic                  berr_q,  berr_d;

    // Next-state logic: acceptance, wait/timeout countdown and release.
    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        tc_d    = tc_q;
        dtack_d = dtack_q;
        berr_d  = berr_q;
        case (state_q)
            ST_IDLE: begin
                // The region and direction are only looked at here: the
                // protection decision and the wait count are both fixed
                // at acceptance, so nothing else needs to remember them.
                if (bus.enable) begin
                    tc_d = TC_ONE;
                    if (bus.rom && !bus.rw && WP_ON) begin
                        state_d = ST_ERR;
                        berr_d  = 1'b1;
                    end else begin
                        wc_d    = bus.rom ? ROM_WC : RAM_WC;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.enable) begin
                    // Master abandoned the cycle; no acknowledge.
                    state_d = ST_IDLE;
                    wc_d    = WC_ZERO;
                    tc_d    = TC_ZERO;
                end else if (wc_q == WC_ZERO && bus.ext_ready) begin
                    // Checked before the timeout so a ready arriving on the
                    // last permitted edge still acknowledges.
                    state_d = ST_ACK;
                    dtack_d = 1'b1;
                end else if (tc_q == TC_MAX) begin
                    state_d = ST_ERR;
                    berr_d  = 1'b1;
                end else begin
                    wc_d = (wc_q == WC_ZERO) ? WC_ZERO : wc_q - 1'b1;
                    tc_d = tc_q + 1'b1;
                end
            end
            ST_ACK: begin
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                    dtack_d = 1'b0;
                    wc_d    = WC_ZERO;
                    tc_d    = TC_ZERO;
                end
            end
            ST_ERR: begin
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                    berr_d  = 1'b0;
                    wc_d    = WC_ZERO;
                    tc_d    = TC_ZERO;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dtack_d = 1'b0;
                berr_d  = 1'b0;
                wc_d    = WC_ZERO;
                tc_d    = TC_ZERO;
            end
        endcase
    end

    // State and counter registers, cleared asynchronously so a reset in the
    // middle of a cycle drops the outputs at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wc_q    <= WC_ZERO;
            tc_q    <= TC_ZERO;
            dtack_q <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            tc_q    <= tc_d;
            dtack_q <= dtack_d;
            berr_q  <= berr_d;
        end
    end

    // Shared open bus lines: driven only while this device is selected, and
    // released combinationally as soon as enable falls.
    assign dtack = bus.enable ? dtack_q : 1'bz;
    assign berr  = bus.enable ? berr_q  : 1'bz;

    // Observation of the internal registers and FSM state.
    assign bus.dtack_r = dtack_q;
    assign bus.berr_r  = berr_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_extmem_ws.sv
// Bench for extmem_ws: two instances with different wait/protection
// settings share the qualifier inputs, each with its own enable.
module tb_extmem_ws;
    localparam int TIMEOUT = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic en0 = 1'b0;
    logic en1 = 1'b0;
    logic rom_s = 1'b0;
    logic rw_s = 1'b1;
    logic rdy_s = 1'b1;

    extmem_ws_if if0 ();
    extmem_ws_if if1 ();

    assign if0.enable    = en0;
    assign if0.rom       = rom_s;
    assign if0.rw        = rw_s;
    assign if0.ext_ready = rdy_s;
    assign if1.enable    = en1;
    assign if1.rom       = rom_s;
    assign if1.rw        = rw_s;
    assign if1.ext_ready = rdy_s;

    wire d0, b0, d1, b1;

    extmem_ws #(.RAM_WAIT(0), .ROM_WAIT(3), .WAIT_WIDTH(4), .TIMEOUT(TIMEOUT),
                .TO_WIDTH(8), .ROM_WP(1))
    u_dut0 (.clk(clk), .reset(rst), .bus(if0.slave), .dtack(d0), .berr(b0));

    extmem_ws #(.RAM_WAIT(1), .ROM_WAIT(3), .WAIT_WIDTH(4), .TIMEOUT(TIMEOUT),
                .TO_WIDTH(8), .ROM_WP(0))
    u_dut1 (.clk(clk), .reset(rst), .bus(if1.slave), .dtack(d1), .berr(b1));

    // Instance settings as seen by the reference expectation.
    int ram_w [2] = '{0, 1};
    int rom_w [2] = '{3, 3};
    int wp    [2] = '{1, 0};

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q [$];   // {kind (0 ack, 1 err), edge offset from E0}

    function automatic logic dt(int i);
        return (i == 0) ? d0 : d1;
    endfunction

    function automatic logic be(int i);
        return (i == 0) ? b0 : b1;
    endfunction

    function automatic logic [1:0] st(int i);
        return (i == 0) ? if0.state : if1.state;
    endfunction

    // Expected outcome of one access; ready_k is the first edge offset at
    // which ext_ready is sampled high (0 = high throughout).
    function automatic logic [9:0] expect_of(int i, logic r, logic w, int ready_k);
        int n;
        int k;
        if (r && !w && wp[i] != 0) return {2'd1, 8'd0};
        n = r ? rom_w[i] : ram_w[i];
        k = n + 1;
        if (ready_k > k) k = ready_k;
        if (k > TIMEOUT) return {2'd1, 8'(TIMEOUT)};
        return {2'd0, 8'(k)};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_en(int i, logic v);
        if (i == 0) en0 = v;
        else        en1 = v;
    endtask

    task automatic start(int i, logic r, logic w, int ready_k);
        rom_s = r;
        rw_s  = w;
        rdy_s = (ready_k <= 1);
        set_en(i, 1'b1);
    endtask

    // Push the expectation, then watch edge by edge (first edge is E0)
    // until dtack or berr rises, and compare against the popped entry.
    task automatic observe(int i, logic r, logic w, int ready_k, string tag);
        logic [9:0] got;
        logic [9:0] exp_v;
        bit seen;
        exp_q.push_back(expect_of(i, r, w, ready_k));
        seen = 0;
        got  = {2'd2, 8'd0};
        for (int j = 0; j < 60 && !seen; j++) begin
            @(posedge clk);
            #1;
            if (dt(i) === 1'b1 || be(i) === 1'b1) begin
                seen = 1;
                got  = {(be(i) === 1'b1) ? 2'd1 : 2'd0, 8'(j)};
            end else begin
                check({tag, "_low"}, {30'd0, dt(i), be(i)}, 32'd0);
                if (ready_k >= 2 && j == ready_k - 1) rdy_s = 1'b1;
            end
        end
        exp_v = exp_q.pop_front();
        check({tag, "_kind"},  {30'd0, got[9:8]}, {30'd0, exp_v[9:8]});
        check({tag, "_lat"},   {24'd0, got[7:0]}, {24'd0, exp_v[7:0]});
        check({tag, "_dtack"}, {31'd0, dt(i)}, {31'd0, exp_v[9:8] == 2'd0});
        check({tag, "_berr"},  {31'd0, be(i)}, {31'd0, exp_v[9:8] == 2'd1});
        // Response must hold while enable stays high.
        @(posedge clk);
        #1;
        check({tag, "_hold"}, {30'd0, dt(i), be(i)},
              {30'd0, exp_v[9:8] == 2'd0, exp_v[9:8] == 2'd1});
    endtask

    // Drop enable: lines release at once, FSM idles on the next edge.
    task automatic release_bus(int i, string tag);
        set_en(i, 1'b0);
        #1;
        check({tag, "_rel_dtack"}, {31'd0, dt(i) === 1'b1}, 32'd0);
        check({tag, "_rel_berr"},  {31'd0, be(i) === 1'b1}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_idle"}, {30'd0, st(i)}, 32'd0);
        rdy_s = 1'b1;
    endtask

    task automatic access(int i, logic r, logic w, int ready_k, string tag);
        start(i, r, w, ready_k);
        observe(i, r, w, ready_k, tag);
        release_bus(i, tag);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_state0", {30'd0, st(0)}, 32'd0);
        check("rst_state1", {30'd0, st(1)}, 32'd0);
        check("rst_dtack0_rel", {31'd0, d0 === 1'b1}, 32'd0);
        check("rst_berr1_rel",  {31'd0, b1 === 1'b1}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Zero-wait RAM read, ROM read with 3 waits.
        access(0, 1'b0, 1'b1, 0, "ram_rd0");
        access(0, 1'b1, 1'b1, 0, "rom_rd0");
        // RAM with one wait and stalled ready, then ready never arriving.
        access(1, 1'b0, 1'b0, 7, "ram_wr_stall");
        access(1, 1'b0, 1'b1, 100, "ram_timeout");
        // ROM write: protected vs unprotected.
        access(0, 1'b1, 1'b0, 0, "rom_wr_wp");
        access(1, 1'b1, 1'b0, 0, "rom_wr_nowp");
        // Ready arriving later than the wait count on a zero-wait region.
        access(0, 1'b0, 1'b0, 3, "ram_wr_rdy3");

        // Abort during WAIT: no acknowledge may follow.
        start(0, 1'b1, 1'b1, 0);
        repeat (2) @(posedge clk);
        #1;
        en0 = 1'b0;
        #1;
        check("abort_rel", {31'd0, d0 === 1'b1}, 32'd0);
        for (int j = 0; j < 6; j++) begin
            @(posedge clk);
            #1;
            check("abort_noack", {30'd0, if0.dtack_r, if0.berr_r}, 32'd0);
        end
        check("abort_idle", {30'd0, st(0)}, 32'd0);
        access(0, 1'b1, 1'b1, 0, "after_abort");

        // Asynchronous reset mid-WAIT with enable held high.
        start(0, 1'b1, 1'b1, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out", {30'd0, d0, b0}, 32'd0);
        check("midrst_state", {30'd0, st(0)}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        observe(0, 1'b1, 1'b1, 0, "post_rst");
        release_bus(0, "post_rst");

        // Ready first seen exactly on the timeout edge: ack wins.
        access(1, 1'b0, 1'b1, TIMEOUT, "to_boundary");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
